// File: rtl/rf_scoreboard_pkg.sv
// Shared CPU constants for the register-file scoreboard: register count,
// pending-counter width, register-address width and the hard-wired zero register.
package rf_scoreboard_pkg;

    localparam int SB_NREG  = 32;
    localparam int SB_CNT_W = 2;
    localparam int REG_AW   = 5;

    localparam logic [REG_AW-1:0] ZERO_REG = '0;

    // True when a register address names a tracked (non-zero) register.
    function automatic logic is_tracked(input logic [REG_AW-1:0] addr);
        return addr != ZERO_REG;
    endfunction

endpackage

// File: rtl/rf_scoreboard_sb_counter.sv
// One saturating up/down pending-write counter with a sticky underflow flag.
// Two independent decrements (retire and squash) may land in the same cycle.
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec_wb,
    input  logic             dec_kill,
    output logic [CNT_W-1:0] cnt,
    output logic             underflow
);

    localparam logic signed [CNT_W+1:0] CNT_MAX = (CNT_W+2)'((1 << CNT_W) - 1);

    logic signed [CNT_W+1:0] sum;

    always_comb begin
        sum = $signed({2'b00, cnt})
            + $signed({{(CNT_W+1){1'b0}}, inc})
            - $signed({{(CNT_W+1){1'b0}}, dec_wb})
            - $signed({{(CNT_W+1){1'b0}}, dec_kill});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            underflow <= 1'b0;
        end else if (sum < 0) begin
            cnt       <= '0;
            underflow <= 1'b1;
        end else if (sum > CNT_MAX) begin
            cnt <= CNT_MAX[CNT_W-1:0];
        end else begin
            cnt <= sum[CNT_W-1:0];
        end
    end

endmodule

// File: rtl/rf_scoreboard.sv
// Register-file scoreboard: counts in-flight writes per register and holds
// back issue on read-after-write hazards or a saturated destination counter.
module rf_scoreboard
    import rf_scoreboard_pkg::*;
#(
    parameter int NREG  = SB_NREG,
    parameter int CNT_W = SB_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic [REG_AW-1:0] issue_rs,
    input  logic [REG_AW-1:0] issue_rt,
    input  logic              issue_rs_use,
    input  logic              issue_rt_use,
    input  logic              issue_wr,
    input  logic [REG_AW-1:0] issue_rd,
    output logic              issue_ready,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              kill_valid,
    input  logic [REG_AW-1:0] kill_rd,
    output logic              busy_any,
    output logic              err_underflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NREG-1:0][CNT_W-1:0] cnt;
    logic [NREG-1:0]            uf;
    logic                       fire;
    logic                       hazard;
    logic                       full;

    // Pending count as seen by a reader this cycle: the register file writes on
    // the falling edge, so a retiring or squashed write no longer blocks a read.
    function automatic logic pending(input logic [CNT_W-1:0] c,
                                     input logic hit_wb,
                                     input logic hit_kill);
        logic signed [CNT_W+1:0] p;
        p = $signed({2'b00, c})
          - $signed({{(CNT_W+1){1'b0}}, hit_wb})
          - $signed({{(CNT_W+1){1'b0}}, hit_kill});
        return p > 0;
    endfunction

    always_comb begin
        hazard = (issue_rs_use && pending(cnt[issue_rs],
                                          wb_valid   && (wb_rd   == issue_rs),
                                          kill_valid && (kill_rd == issue_rs)))
              || (issue_rt_use && pending(cnt[issue_rt],
                                          wb_valid   && (wb_rd   == issue_rt),
                                          kill_valid && (kill_rd == issue_rt)));
        // Fullness ignores same-cycle decrements to keep the ready path short.
        full   = issue_wr && is_tracked(issue_rd) && (cnt[issue_rd] == CNT_MAX);
    end

    assign issue_ready = !hazard && !full;
    assign fire        = issue_valid && issue_ready;

    assign cnt[ZERO_REG] = '0;
    assign uf[ZERO_REG]  = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_cnt
        sb_counter #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .clk      (clk),
            .rst      (rst),
            .inc      (fire && issue_wr && (issue_rd == REG_AW'(r))),
            .dec_wb   (wb_valid   && (wb_rd   == REG_AW'(r))),
            .dec_kill (kill_valid && (kill_rd == REG_AW'(r))),
            .cnt      (cnt[r]),
            .underflow(uf[r])
        );
    end

    assign busy_any      = |cnt;
    assign err_underflow = |uf;

endmodule
